// File: rtl/mem_wb_skid_if.sv
// MEM->WB handshake bundle: upstream entry with payload, downstream head entry.
// The master side is whoever drives entries in and consumes the head; slave is the register.
interface mem_wb_skid_if #(
  parameter int WORD_WIDTH   = 32,
  parameter int REG_ADDR_LEN = 4
);
  logic                    in_valid;
  logic                    in_ready;
  logic [REG_ADDR_LEN-1:0] dst;
  logic [WORD_WIDTH-1:0]   ALU_res;
  logic [WORD_WIDTH-1:0]   mem_data;
  logic                    mem_read;
  logic                    WB_en;

  logic                    out_valid;
  logic                    out_ready;
  logic [REG_ADDR_LEN-1:0] dst_out;
  logic [WORD_WIDTH-1:0]   ALU_res_out;
  logic [WORD_WIDTH-1:0]   mem_data_out;
  logic                    mem_read_out;
  logic                    WB_en_out;
  logic [WORD_WIDTH-1:0]   wb_value;

  modport master (
    output in_valid, dst, ALU_res, mem_data, mem_read, WB_en, out_ready,
    input  in_ready, out_valid, dst_out, ALU_res_out, mem_data_out,
           mem_read_out, WB_en_out, wb_value
  );

  modport slave (
    input  in_valid, dst, ALU_res, mem_data, mem_read, WB_en, out_ready,
    output in_ready, out_valid, dst_out, ALU_res_out, mem_data_out,
           mem_read_out, WB_en_out, wb_value
  );
endinterface

// File: rtl/mem_wb_skid_reg.sv
// Two-entry MEM/WB skid register: in_ready comes only from registered state, so the
// WB-side out_ready never reaches the upstream ready path combinationally.
module mem_wb_skid_reg #(
  parameter int WORD_WIDTH   = 32,
  parameter int REG_ADDR_LEN = 4,
  parameter int CNT_WIDTH    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  mem_wb_skid_if.slave         bus,
  output logic [1:0]           occupancy,
  output logic [CNT_WIDTH-1:0] drop_cnt
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  typedef struct packed {
    logic [REG_ADDR_LEN-1:0] dst;
    logic [WORD_WIDTH-1:0]   alu_res;
    logic [WORD_WIDTH-1:0]   mem_data;
    logic                    mem_read;
    logic                    wb_en;
  } entry_t;

  function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] a,
                                                   input logic [1:0]           inc);
    logic [CNT_WIDTH:0] sum;
    sum = {1'b0, a} + {{(CNT_WIDTH-1){1'b0}}, inc};
    return sum[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : sum[CNT_WIDTH-1:0];
  endfunction

  logic [1:0]           state_q, state_d;
  entry_t               main_q, main_d;
  entry_t               skid_q, skid_d;
  logic [CNT_WIDTH-1:0] drop_q, drop_d;
  entry_t               in_entry;
  logic                 accept, consume;
  logic [1:0]           drop_inc;

  assign in_entry = {bus.dst, bus.ALU_res, bus.mem_data, bus.mem_read, bus.WB_en};

  assign bus.in_ready  = (state_q != ST_FULL);
  assign bus.out_valid = (state_q != ST_EMPTY);
  assign accept        = bus.in_valid & bus.in_ready;
  assign consume       = bus.out_valid & bus.out_ready;
  // State encoding doubles as the entry count.
  assign drop_inc      = state_q + {1'b0, accept};

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    drop_d  = drop_q;
    if (flush) begin
      state_d = ST_EMPTY;
      drop_d  = sat_add(drop_q, drop_inc);
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d = ST_ONE;
            main_d  = in_entry;
          end
        end
        ST_ONE: begin
          if (accept && consume) begin
            main_d = in_entry;
          end else if (accept) begin
            state_d = ST_FULL;
            skid_d  = in_entry;
          end else if (consume) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (consume) begin
            state_d = ST_ONE;
            main_d  = skid_q;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      drop_q  <= drop_d;
    end
  end

  // Head of the queue is always the main register.
  assign bus.dst_out      = main_q.dst;
  assign bus.ALU_res_out  = main_q.alu_res;
  assign bus.mem_data_out = main_q.mem_data;
  assign bus.mem_read_out = main_q.mem_read;
  assign bus.WB_en_out    = main_q.wb_en & bus.out_valid;
  assign bus.wb_value     = main_q.mem_read ? main_q.mem_data : main_q.alu_res;

  assign occupancy = state_q;
  assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_mem_wb_skid_reg.sv
// Bench for mem_wb_skid_reg: directed vector table, queue-model scoreboard with random
// traffic, and an asynchronous mid-cycle reset; a CNT_WIDTH=2 copy shares all stimulus.
module tb_mem_wb_skid_reg;
  localparam int WW = 32;
  localparam int RA = 4;

  typedef struct packed {
    logic [RA-1:0] dst;
    logic [WW-1:0] alu;
    logic [WW-1:0] mem;
    logic          mr;
    logic          wb;
  } entry_t;

  typedef struct {
    logic          iv;
    logic          ordy;
    logic          fl;
    entry_t        e;
    int            e_occ;
    logic          e_ir;
    logic [WW-1:0] e_wbv;
    logic          e_wben;
    int            e_drop;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  entry_t        drv = '0;
  logic [1:0]    occ, occ2;
  logic [7:0]    drop;
  logic [1:0]    drop2;

  int            n_tests = 0;
  int            n_fail = 0;
  entry_t        sb[$];
  int            drop_m = 0;
  vec_t          vecs[19];

  mem_wb_skid_if #(.WORD_WIDTH(WW), .REG_ADDR_LEN(RA)) bus ();
  mem_wb_skid_if #(.WORD_WIDTH(WW), .REG_ADDR_LEN(RA)) bus2 ();

  assign bus.in_valid   = in_valid;
  assign bus.out_ready  = out_ready;
  assign bus.dst        = drv.dst;
  assign bus.ALU_res    = drv.alu;
  assign bus.mem_data   = drv.mem;
  assign bus.mem_read   = drv.mr;
  assign bus.WB_en      = drv.wb;
  assign bus2.in_valid  = in_valid;
  assign bus2.out_ready = out_ready;
  assign bus2.dst       = drv.dst;
  assign bus2.ALU_res   = drv.alu;
  assign bus2.mem_data  = drv.mem;
  assign bus2.mem_read  = drv.mr;
  assign bus2.WB_en     = drv.wb;

  mem_wb_skid_reg #(.WORD_WIDTH(WW), .REG_ADDR_LEN(RA), .CNT_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus), .occupancy(occ), .drop_cnt(drop)
  );

  mem_wb_skid_reg #(.WORD_WIDTH(WW), .REG_ADDR_LEN(RA), .CNT_WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus2), .occupancy(occ2), .drop_cnt(drop2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic entry_t ent(input logic [RA-1:0] d, input logic [WW-1:0] a,
                                 input logic [WW-1:0] m, input logic mr, input logic wb);
    entry_t e;
    e.dst = d; e.alu = a; e.mem = m; e.mr = mr; e.wb = wb;
    return e;
  endfunction

  function automatic vec_t mk(input logic iv, input logic ordy, input logic fl, input entry_t e,
                              input int occ_e, input logic ir, input logic [WW-1:0] wbv,
                              input logic wben, input int dr);
    vec_t v;
    v.iv = iv; v.ordy = ordy; v.fl = fl; v.e = e; v.e_occ = occ_e; v.e_ir = ir;
    v.e_wbv = wbv; v.e_wben = wben; v.e_drop = dr;
    return v;
  endfunction

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  // Reference queue: flush drops everything held plus the same-cycle accept.
  task automatic model_step();
    bit acc, cons;
    acc  = in_valid && (sb.size() < 2);
    cons = out_ready && (sb.size() > 0);
    if (flush) begin
      drop_m += sb.size() + (acc ? 1 : 0);
      sb.delete();
    end else begin
      if (cons) void'(sb.pop_front());
      if (acc) sb.push_back(drv);
    end
  endtask

  task automatic check_sb();
    chk("sb_out_valid", bus.out_valid, (sb.size() != 0));
    chk("sb_occupancy", occ, sb.size());
    chk("sb_in_ready", bus.in_ready, (sb.size() < 2));
    chk("sb_occupancy2", occ2, sb.size());
    if (sb.size() > 0) begin
      chk("sb_dst", bus.dst_out, sb[0].dst);
      chk("sb_alu", bus.ALU_res_out, sb[0].alu);
      chk("sb_mem", bus.mem_data_out, sb[0].mem);
      chk("sb_mem_read", bus.mem_read_out, sb[0].mr);
      chk("sb_wb_en", bus.WB_en_out, sb[0].wb);
      chk("sb_wb_value", bus.wb_value, sb[0].mr ? sb[0].mem : sb[0].alu);
    end else begin
      chk("sb_wb_en_idle", bus.WB_en_out, 1'b0);
    end
  endtask

  task automatic cycle(input logic iv, input logic ordy, input logic fl, input entry_t e);
    in_valid = iv; out_ready = ordy; flush = fl; drv = e;
    model_step();
    @(posedge clk);
    #1;
    check_sb();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_out_valid"}, bus.out_valid, 1'b0);
    chk({tag, "_wb_en_out"}, bus.WB_en_out, 1'b0);
    chk({tag, "_wb_value"}, bus.wb_value, '0);
    chk({tag, "_occupancy"}, occ, 2'd0);
    chk({tag, "_in_ready"}, bus.in_ready, 1'b1);
    chk({tag, "_drop_cnt"}, drop, 8'd0);
    chk({tag, "_drop_cnt2"}, drop2, 2'd0);
  endtask

  initial begin
    entry_t z;
    z = '0;
    vecs[0]  = mk(1, 1, 0, ent(3, 'h10, 0, 0, 1),          1, 1, 'h10,   1, 0);
    vecs[1]  = mk(0, 1, 0, z,                              0, 1, 0,      0, 0);
    vecs[2]  = mk(1, 1, 0, ent(5, 'h40, 'hDEAD, 1, 1),     1, 1, 'hDEAD, 1, 0);
    vecs[3]  = mk(0, 1, 0, z,                              0, 1, 0,      0, 0);
    vecs[4]  = mk(1, 0, 0, ent(1, 'h111, 0, 0, 0),         1, 1, 'h111,  0, 0);
    vecs[5]  = mk(1, 0, 0, ent(2, 'h222, 0, 0, 1),         2, 0, 'h111,  0, 0);
    vecs[6]  = mk(1, 0, 0, ent(7, 'h333, 0, 0, 1),         2, 0, 'h111,  0, 0);
    vecs[7]  = mk(0, 1, 0, z,                              1, 1, 'h222,  1, 0);
    vecs[8]  = mk(0, 1, 0, z,                              0, 1, 0,      0, 0);
    vecs[9]  = mk(1, 0, 0, ent(8, 'hA1, 0, 0, 1),          1, 1, 'hA1,   1, 0);
    vecs[10] = mk(1, 0, 0, ent(9, 'hA2, 0, 0, 1),          2, 0, 'hA1,   1, 0);
    vecs[11] = mk(1, 0, 1, ent(10, 'hA3, 0, 0, 1),         0, 1, 0,      0, 2);
    vecs[12] = mk(1, 0, 0, ent(11, 'hB1, 0, 0, 1),         1, 1, 'hB1,   1, 2);
    vecs[13] = mk(1, 0, 1, ent(12, 'hB2, 0, 0, 1),         0, 1, 0,      0, 4);
    vecs[14] = mk(1, 0, 0, ent(13, 'hB3, 0, 0, 0),         1, 1, 'hB3,   0, 4);
    vecs[15] = mk(1, 0, 0, ent(14, 'hB4, 0, 0, 1),         2, 0, 'hB3,   0, 4);
    vecs[16] = mk(0, 0, 1, z,                              0, 1, 0,      0, 6);
    vecs[17] = mk(1, 1, 0, ent(15, 'hC1, 'h5, 1, 1),       1, 1, 'h5,    1, 6);
    vecs[18] = mk(0, 1, 1, z,                              0, 1, 0,      0, 7);

    #12;
    check_reset_outputs("rst_hold");
    #10 rst = 1'b0;
    @(posedge clk);
    #1;
    check_reset_outputs("rst_after");

    for (int i = 0; i < 19; i++) begin
      cycle(vecs[i].iv, vecs[i].ordy, vecs[i].fl, vecs[i].e);
      chk($sformatf("v%0d_occupancy", i), occ, vecs[i].e_occ);
      chk($sformatf("v%0d_out_valid", i), bus.out_valid, (vecs[i].e_occ != 0));
      chk($sformatf("v%0d_in_ready", i), bus.in_ready, vecs[i].e_ir);
      chk($sformatf("v%0d_wb_en_out", i), bus.WB_en_out, vecs[i].e_wben);
      chk($sformatf("v%0d_drop_cnt", i), drop, vecs[i].e_drop);
      chk($sformatf("v%0d_drop_cnt_sat", i), drop2, sat(vecs[i].e_drop, 3));
      if (vecs[i].e_occ != 0)
        chk($sformatf("v%0d_wb_value", i), bus.wb_value, vecs[i].e_wbv);
    end

    for (int i = 0; i < 300; i++) begin
      entry_t e;
      e = ent(RA'($urandom), $urandom, $urandom, 1'($urandom), 1'($urandom));
      cycle(1'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0), e);
      chk("rnd_drop_cnt", drop, sat(drop_m, 255));
      chk("rnd_drop_cnt_sat", drop2, sat(drop_m, 3));
    end

    cycle(1, 0, 0, ent(4, 'h77, 0, 0, 1));
    cycle(1, 0, 0, ent(6, 'h88, 0, 0, 1));
    chk("prerst_occupancy", occ, 2'd2);
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    #3 rst = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    #2 rst = 1'b0;
    sb.delete();
    drop_m = 0;
    @(posedge clk);
    #1;
    check_reset_outputs("async_rst_after");

    cycle(1, 1, 0, ent(3, 'h10, 0, 0, 1));
    chk("post_rst_wb_value", bus.wb_value, 32'h10);
    chk("post_rst_wb_en_out", bus.WB_en_out, 1'b1);
    cycle(0, 1, 0, '0);
    chk("post_rst_drained", bus.out_valid, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
